// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that shares one UART TX
// byte port among NUM_REQ requesters. A grant is held for a whole packet
// (closed by last) so bytes from different sources never interleave. A stall
// watchdog revokes a grant whose owner stops supplying bytes mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              terr_q, terr_d;
  logic [ID_W:0]     pick;
  logic              sel_valid, sel_last, handshake;

  // First asserted request at or after ptr, wrapping; returns {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (v[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  // Pointer to the requester after g, wrapping NUM_REQ-1 back to 0.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

  // The granted requester drives the TX port directly; no path from the others.
  assign sel_valid   = req_valid[grant_q];
  assign sel_last    = req_last[grant_q];
  assign tx_data     = req_data[grant_q*DATA_W +: DATA_W];
  assign grant_id    = grant_q;
  assign busy        = (state_q == STREAM);
  assign timeout_err = terr_q;

  // Next-state, grant, watchdog and handshake steering.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    stall_d   = stall_q;
    terr_d    = 1'b0;
    tx_valid  = 1'b0;
    req_ready = '0;
    handshake = 1'b0;
    pick      = rr_pick(req_valid, rr_q);
    case (state_q)
      IDLE: begin
        if (pick[ID_W]) begin
          grant_d = pick[ID_W-1:0];
          stall_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        tx_valid           = sel_valid;
        req_ready[grant_q] = tx_ready;
        handshake          = sel_valid && tx_ready;
        if (handshake) begin
          // An accepted byte always beats a watchdog expiry in the same cycle.
          stall_d = '0;
          if (sel_last) begin
            state_d = IDLE;
            rr_d    = next_ptr(grant_q);
          end
        end else if ((TIMEOUT > 0) && (stall_q == CNT_LIMIT)) begin
          state_d = IDLE;
          rr_d    = next_ptr(grant_q);
          stall_d = '0;
          terr_d  = 1'b1;
        end else if ((TIMEOUT > 0) && !sel_valid) begin
          // Only an absent owner counts; a stalled UART is not its fault.
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, round-robin pointer, stall counter and abort pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a packet-level reference
// model of ownership / fairness / watchdog, directed scenarios and random traffic.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, tx_ready;
  logic [1:0]      grant_id;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } beat_t;

  beat_t q[NR][$];
  logic  rdy_pat[$];
  int    ready_pct;
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model: who owns the port (-1 = nobody), fairness pointer,
  // owner-absent cycle count, and the expected abort pulse.
  int   m_owner, m_gid, m_ptr, m_stall;
  logic m_terr;

  int   glog[$];
  logic prev_busy;
  int   hs_cnt, terr_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l, input int gap);
    beat_t b;
    b.d = d; b.l = l; b.gap = gap;
    q[i].push_back(b);
  endtask

  // Grant order encoded as octal digits, 7 marking a missing grant.
  function automatic int glog_code(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c = c * 8 + ((k < glog.size()) ? glog[k] : 7);
    return c;
  endfunction

  // Requester behaviour after a clock edge: retire accepted bytes, then present
  // the next queued byte once its idle gap has elapsed. Data stays put until taken.
  task automatic drive(input logic [NR-1:0] acc);
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        void'(q[i].pop_front());
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && q[i].size() > 0) begin
        b = q[i][0];
        if (b.gap > 0) begin
          b.gap = b.gap - 1;
          q[i][0] = b;
        end else begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = b.d;
          req_last[i]          = b.l;
        end
      end
    end
    if (rdy_pat.size() > 0) tx_ready = rdy_pat.pop_front();
    else                    tx_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic check_outputs();
    logic [NR-1:0] e_rdy;
    logic          e_vld;
    e_rdy = '0;
    e_vld = 1'b0;
    if (m_owner >= 0) begin
      e_vld = req_valid[m_owner];
      if (tx_ready) e_rdy[m_owner] = 1'b1;
    end
    check("busy",        32'(busy),        32'(m_owner >= 0));
    check("grant_id",    32'(grant_id),    m_gid);
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("tx_valid",    32'(tx_valid),    32'(e_vld));
    check("req_ready",   32'(req_ready),   32'(e_rdy));
    if (e_vld) check("tx_data", 32'(tx_data), 32'(req_data[m_owner*DW +: DW]));
  endtask

  // Advance the reference by one clock using the inputs present at the edge.
  task automatic model_step();
    logic found;
    int   idx;
    if (m_owner < 0) begin
      m_terr = 1'b0;
      found  = 1'b0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!found && req_valid[idx]) begin
          found   = 1'b1;
          m_owner = idx;
          m_gid   = idx;
          m_stall = 0;
        end
      end
    end else if (req_valid[m_owner] && tx_ready) begin
      m_terr  = 1'b0;
      m_stall = 0;
      if (req_last[m_owner]) begin
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end else if (m_stall == TO) begin
      m_terr  = 1'b1;
      m_ptr   = (m_owner + 1) % NR;
      m_owner = -1;
      m_stall = 0;
    end else begin
      m_terr = 1'b0;
      if (!req_valid[m_owner]) m_stall++;
    end
  endtask

  task automatic cycle();
    logic [NR-1:0] acc;
    @(negedge clk);
    check_outputs();
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    if (tx_valid && tx_ready) hs_cnt++;
    if (timeout_err) terr_cnt++;
    acc = req_valid & req_ready;
    @(posedge clk);
    model_step();
    #1;
    drive(acc);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) q[i].delete();
    rdy_pat.delete();
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    ready_pct = 100;
    m_owner = -1; m_gid = 0; m_ptr = 0; m_stall = 0; m_terr = 1'b0;
    glog.delete(); prev_busy = 1'b0; hs_cnt = 0; terr_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    #3;
    check("reset_busy",      32'(busy),        32'd0);
    check("reset_tx_valid",  32'(tx_valid),    32'd0);
    check("reset_req_ready", 32'(req_ready),   32'd0);
    check("reset_grant_id",  32'(grant_id),    32'd0);
    check("reset_terr",      32'(timeout_err), 32'd0);

    // Basic three-byte packet from requester 1.
    do_reset();
    push(1, 8'h41, 1'b0, 0); push(1, 8'h42, 1'b0, 0); push(1, 8'h43, 1'b1, 0);
    drive('0);
    run(8);
    check("basic_grants", glog_code(2), 32'o17);
    check("basic_bytes",  hs_cnt, 3);

    // Round-robin fairness: all four streaming 2-byte packets.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < NR; i++) begin
        push(i, 8'(i * 16 + p * 2),     1'b0, 0);
        push(i, 8'(i * 16 + p * 2 + 1), 1'b1, 0);
      end
    drive('0);
    run(45);
    check("rr_order", glog_code(6), 32'o012301);
    check("rr_bytes", hs_cnt, 24);

    // Packet locking: req0 (and req3) arrive while req2 streams 5 bytes.
    do_reset();
    for (int b = 0; b < 5; b++) push(2, 8'(8'h20 + b), (b == 4), 0);
    push(0, 8'h0A, 1'b1, 2);
    push(3, 8'h3A, 1'b1, 3);
    drive('0);
    run(16);
    check("lock_order_r3", glog_code(4), 32'o2307);

    do_reset();
    for (int b = 0; b < 5; b++) push(2, 8'(8'h20 + b), (b == 4), 0);
    push(0, 8'h0A, 1'b1, 2);
    drive('0);
    run(14);
    check("lock_order_r0", glog_code(3), 32'o207);

    // Backpressure with long tx_ready=0 stretches while data is valid.
    do_reset();
    for (int b = 0; b < 4; b++) push(1, 8'(8'h50 + b), (b == 3), 0);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    drive('0);
    run(20);
    check("bp_bytes", hs_cnt, 4);
    check("bp_no_timeout", terr_cnt, 0);

    // Watchdog: req1 goes silent mid-packet, req2 waits.
    do_reset();
    push(1, 8'h10, 1'b0, 0); push(1, 8'h11, 1'b1, 10);
    push(2, 8'h20, 1'b1, 1);
    drive('0);
    run(24);
    check("wd_pulses", terr_cnt, 1);
    check("wd_order",  glog_code(4), 32'o1217);

    // Watchdog variant: the missing byte turns up exactly on the expiry cycle.
    do_reset();
    push(1, 8'h10, 1'b0, 0); push(1, 8'h11, 1'b1, 4);
    push(2, 8'h20, 1'b1, 1);
    drive('0);
    run(16);
    check("wd_edge_pulses", terr_cnt, 0);
    check("wd_edge_order",  glog_code(3), 32'o127);
    check("wd_edge_bytes",  hs_cnt, 3);

    // Reset in the middle of a packet, after the pointer has moved to 2.
    do_reset();
    push(1, 8'h60, 1'b1, 0);
    for (int b = 0; b < 4; b++) push(1, 8'(8'h70 + b), (b == 3), 0);
    drive('0);
    run(5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",      32'(busy),        32'd0);
    check("midrst_tx_valid",  32'(tx_valid),    32'd0);
    check("midrst_req_ready", 32'(req_ready),   32'd0);
    check("midrst_grant_id",  32'(grant_id),    32'd0);
    check("midrst_terr",      32'(timeout_err), 32'd0);
    do_reset();
    push(3, 8'h33, 1'b1, 0);
    push(0, 8'h03, 1'b1, 0);
    drive('0);
    run(8);
    check("midrst_order", glog_code(3), 32'o037);

    // Random traffic with backpressure and occasional owner stalls.
    do_reset();
    ready_pct = 75;
    drive('0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (q[i].size() == 0 && !req_valid[i] && $urandom_range(3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push(i, 8'($urandom), (b == len - 1),
                 ($urandom_range(9) < 8) ? $urandom_range(2) : $urandom_range(4, 8));
        end
      end
      cycle();
    end
    check("rand_activity", 32'(hs_cnt > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmitter byte interface among up to NUM_REQ on-chip requesters (command responder, status reporter, debug streams). It sits between the requesters and the UART TX core's valid/ready byte port. It locks the grant for a whole packet, delimited by `last`, so bytes from different sources never interleave on `uart_tx`. A stall watchdog releases a grant whose owner stops supplying bytes mid-packet.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `TIMEOUT`, default 1_000_000: stall cycles before a mid-packet grant is revoked; 0 disables the watchdog.
- `clk` in 1: system clock; all logic in this single domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last` in NUM_REQ: byte is the final byte of the packet.
- `req_ready` out NUM_REQ: per-requester byte accepted.
- `tx_data` out DATA_W: byte to the UART TX core.
- `tx_valid` out 1: byte valid to the UART TX core.
- `tx_ready` in 1: UART TX core can accept a byte.
- `grant_id` out clog2(NUM_REQ): current or last owner.
- `busy` out 1: a packet grant is held.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- Reset values: state IDLE, `grant_id`=0, rr pointer=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `timeout_err`=0, stall counter=0.
- The FSM has two states: IDLE and STREAM.
- IDLE behaviour:
  - If any `req_valid` is high, select the first asserted index searching from the rr pointer upward, wrapping modulo NUM_REQ.
  - Register that index into `grant_id`, set `busy`, and go to STREAM.
  - No byte transfers in IDLE: `tx_valid`=0 and `req_ready`=0.
- STREAM behaviour, with g=`grant_id`:
  - `tx_valid` = `req_valid[g]` and `tx_data` = `req_data[g]` (combinational mux).
  - `req_ready[g]` = `tx_ready`; all other `req_ready` bits are 0.
  - A handshake is `tx_valid && tx_ready`.
  - Handshake with `req_last[g]`=1: go to IDLE, clear `busy`, rr pointer = (g+1) mod NUM_REQ.
  - Handshake without last: stay in STREAM.
- Watchdog (TIMEOUT>0):
  - The stall counter increments each STREAM cycle with `req_valid[g]`=0.
  - It clears on any handshake and on entry to STREAM.
  - Cycles with `req_valid[g]`=1 but `tx_ready`=0 do not count, because a stalled UART is not a requester fault.
  - When the counter reaches TIMEOUT: pulse `timeout_err` for 1 cycle, go to IDLE, clear `busy`, rr pointer = g+1. The rest of the aborted packet arrives later as a fresh arbitration.
- Requests from non-granted requesters are held off (`req_ready`=0) and must keep data stable until accepted (AXI-stream rules).
- `grant_id` holds its value in IDLE until the next grant.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle n allows the first byte to transfer at the earliest in cycle n+1.
- Between packets there is exactly 1 IDLE cycle minimum. Back-to-back packets from one source run last-byte cycle n, IDLE n+1, next first byte n+2 at the earliest.
- Throughput inside a packet: 1 byte/cycle when `tx_ready` is held high. Real throughput is paced by the UART core.
- Single-byte packet (`last` on the first byte): STREAM lasts 1 cycle when `tx_ready`=1.
- Simultaneous handshake and watchdog expiry in the same cycle: the handshake wins. The byte is accepted, the counter clears, and there is no `timeout_err`.
- rr pointer wrap: g=NUM_REQ-1 wraps to 0.
- Asynchronous reset mid-packet: immediate return to reset values; the partial packet is lost and no `timeout_err` is raised.
- `req_ready` and `tx_valid` have a combinational path from `tx_ready` and `req_valid[g]` respectively. There is no combinational path from non-granted inputs.

## Test plan
- **Basic packet:** NUM_REQ=4, req1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), `tx_ready`=1.
  - `grant_id`=1 one cycle after request.
  - `tx_data` shows 0x41/0x42/0x43 on three consecutive cycles.
  - `busy` drops the cycle after 0x43.
- **Round-robin fairness:** all four requesters continuously send 2-byte packets.
  - Grant order is 0,1,2,3,0,1.
  - No byte interleaving within a packet.
  - One idle cycle between packets.
- **Packet locking under contention:** req2 is streaming a 5-byte packet; req0 raises `req_valid` at byte 2.
  - `req_ready[0]` stays 0 until req2's last byte.
  - The next grant is 3 if req3 is requesting, otherwise 0.
- **Backpressure:** `tx_ready` toggles 1,0,0,1 during a 4-byte packet.
  - `tx_data` stays stable while stalled.
  - Exactly 4 handshakes occur.
  - No `timeout_err` with TIMEOUT=4, even with long `tx_ready`=0 stretches.
- **Watchdog:** TIMEOUT=4, req1 sends 1 byte without last, then drops `req_valid`.
  - `timeout_err` pulses 4 cycles later, `busy`=0.
  - A pending req2 is granted next.
  - A variant handshakes on the expiry cycle; it must be accepted with no pulse.
- **Reset mid-packet:** `rst_n` asserted during byte 2 of a packet.
  - All outputs take reset values immediately.
  - After release, the first grant goes to the lowest requesting index from pointer 0.
